btn_debounce: RTL and testbench
===============================

// Module: btn_debounce
// PURPOSE
//  Debounces N_BTN raw push-buttons and emits one clean single-cycle pulse per press.
//  Sits directly upstream of the ALU input control: its o_btn_pulse[2:0] drive
//  i_button_A / i_button_B / i_button_Op in alu_top, so each press latches exactly once.
// PARAMETERS
//  N_BTN           3        number of independent button channels
//  DEBOUNCE_CYCLES 1000000  consecutive stable synchronised samples needed to accept a level (>=2)
//  REPEAT_DELAY    50000000 cycles held in PRESSED before the first auto-repeat pulse (BTN_AUTOREPEAT_EN only)
//  REPEAT_PERIOD   10000000 cycles between subsequent auto-repeat pulses (BTN_AUTOREPEAT_EN only)
// PORTS
//  i_clock        in   1      system clock, all logic on rising edge
//  i_reset        in   1      asynchronous, active-low reset
//  i_btn_raw      in   N_BTN  raw asynchronous button inputs, 1 = pressed
//  o_btn_pulse    out  N_BTN  1-cycle pulse per accepted press (and per repeat)
//  o_btn_level    out  N_BTN  debounced level, 1 while channel is in PRESSED/RELEASE_WAIT
// BEHAVIOUR
//  - Reset (i_reset=0, async assert, sync-to-clock release is the system's job): sync flops=0,
//    all FSMs=IDLE, counters=0, o_btn_pulse=0, o_btn_level=0. Reset mid-count discards progress.
//  - Each channel: 2-flop synchroniser, then 4-state FSM, channels fully independent.
//  - IDLE: sync=1 -> PRESS_WAIT, cnt=1. sync=0 -> stay.
//  - PRESS_WAIT: sync=1 -> cnt++; when cnt reaches DEBOUNCE_CYCLES -> PRESSED, o_btn_pulse=1 for
//    that one cycle, o_btn_level=1. sync=0 (glitch) -> IDLE, cnt=0, no pulse.
//  - PRESSED: sync=0 -> RELEASE_WAIT, cnt=1. sync=1 -> stay (repeat logic below).
//  - RELEASE_WAIT: sync=0 -> cnt++; at DEBOUNCE_CYCLES -> IDLE, o_btn_level=0.
//    sync=1 -> PRESSED, cnt=0, NO new pulse (bounce on release is not a press).
//  - Latency raw rise -> pulse: 2 (sync) + DEBOUNCE_CYCLES clock cycles, exact.
//  - Counter width $clog2(DEBOUNCE_CYCLES+1); saturates, never wraps.
//  - Outputs registered; o_btn_pulse never high two consecutive cycles on one channel.
//  - Simultaneous presses on several channels: each pulses in its own qualifying cycle.
// CONFIGURATION
//  - Macro BTN_AUTOREPEAT_EN defined: in PRESSED a separate hold counter runs; after REPEAT_DELAY
//    cycles emit a pulse, then one every REPEAT_PERIOD while held. Hold counter clears on leaving
//    PRESSED. Entering RELEASE_WAIT pauses repeats; return to PRESSED restarts the delay.
//  - Not defined: hold counter and repeat logic absent; exactly one pulse per press.
// STRUCTURE
//  - Shared package/header btn_pkg: FSM state localparams ST_IDLE=2'd0, ST_PRESS_WAIT=2'd1,
//    ST_PRESSED=2'd2, ST_RELEASE_WAIT=2'd3; default timing constants for 100 MHz board clock.
//  - Sub-module btn_debounce_ch: one channel (sync + FSM + counters); btn_debounce
//    instantiates N_BTN of them in a generate loop and concatenates outputs.
// TESTING (bench: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
//  1 Reset: drive i_reset=0 with i_btn_raw=3'b111 -> o_btn_pulse=0, o_btn_level=0 throughout;
//    release reset -> first pulse exactly 2+4 cycles after first sampled edge.
//  2 Clean press ch0: raw[0] 0->1 held 30 cycles -> single pulse on bit0 at +6, level=1 until
//    6 cycles after release.
//  3 Bounce: raw[1] toggles 1,0,1,0 each cycle then steady 1 -> no pulse during toggling,
//    one pulse 6 cycles after steady 1 starts.
//  4 Release bounce: held ch2 drops for 2 cycles then returns high -> level stays 1, no 2nd pulse.
//  5 Simultaneous: raw=3'b101 same cycle -> pulses on bits 0 and 2 in the same cycle, bit1 quiet.
//  6 BTN_AUTOREPEAT_EN: hold ch0 60 cycles -> pulses at +6, +26, +34, +42, +50, +58; without
//    macro -> only +6. Reset asserted at +30 -> outputs 0 immediately, no further pulses.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding, default timing constants (100 MHz board clock)
// and counter sizing helper for the button debouncer.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 100 MHz
    localparam int unsigned DEF_N_BTN           = 3;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel (2-flop synchroniser, debounce FSM, counters).
// Auto-repeat while held is built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_pulse,
    output logic o_level
);

    localparam int unsigned       CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       sync_q, sync_d;
    logic             sync_s;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;
    logic             rep_fire;

    assign sync_s  = sync_q[1];
    assign o_pulse = pulse_q;
    assign o_level = level_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = cnt_width(HOLD_MAX);

    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc, hold_target;
    logic              rep_q, rep_d;

    // Hold counter only advances while staying in PRESSED; any other cycle clears it,
    // so a release bounce restarts the initial delay rather than the period.
    always_comb begin
        hold_inc    = hold_q + HOLD_W'(1);
        hold_target = rep_q ? HOLD_W'(REPEAT_PERIOD) : HOLD_W'(REPEAT_DELAY);
        hold_d      = '0;
        rep_d       = 1'b0;
        rep_fire    = 1'b0;
        if (state_q == ST_PRESSED && sync_s) begin
            hold_d = hold_inc;
            rep_d  = rep_q;
            if (hold_inc == hold_target) begin
                rep_fire = 1'b1;
                hold_d   = '0;
                rep_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end
`else
    logic unused_repeat_cfg;

    always_comb begin
        rep_fire          = 1'b0;
        unused_repeat_cfg = (REPEAT_DELAY != REPEAT_PERIOD);
    end
`endif

    always_comb begin
        sync_d  = {sync_q[0], i_raw};
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        level_d = level_q;
        case (state_q)
            ST_IDLE: begin
                if (sync_s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (sync_s) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                        level_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_PRESSED: begin
                if (sync_s) begin
                    pulse_d = rep_fire;
                end else begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (!sync_s) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        level_d = 1'b0;
                    end
                end else begin
                    // bounce back to high is still the same press: no pulse
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_q  <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: N_BTN independent debounced push-buttons, one clean pulse per press.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses on every channel.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN           = DEF_N_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [N_BTN-1:0] i_btn_raw,
    output logic [N_BTN-1:0] o_btn_pulse,
    output logic [N_BTN-1:0] o_btn_level
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .i_clock(i_clock),
            .i_reset(i_reset),
            .i_raw  (i_btn_raw[i]),
            .o_pulse(o_btn_pulse[i]),
            .o_level(o_btn_level[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Testbench for btn_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Follows BTN_AUTOREPEAT_EN in the same way as the design.
module tb_btn_debounce;

    localparam int unsigned NB = 3;
    localparam int unsigned D  = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 8;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] raw   = '0;
    logic [NB-1:0] pulse, level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    btn_debounce #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst_n),
        .i_btn_raw  (raw),
        .o_btn_pulse(pulse),
        .o_btn_level(level)
    );

    // Reference model: a press/release is accepted once D consecutive samples, taken two
    // edges late, disagree with the accepted level; repeats are timed from acceptance.
    logic [NB-1:0] m_d1, m_d2, m_lvl, m_prev, exp_pulse;
    int unsigned   m_run  [NB];
    int unsigned   m_hold [NB];

    task automatic model_clear();
        m_d1 = '0; m_d2 = '0; m_lvl = '0; m_prev = '0; exp_pulse = '0;
        for (int c = 0; c < NB; c++) begin
            m_run[c]  = 0;
            m_hold[c] = 0;
        end
    endtask

    task automatic model_edge();
        logic [NB-1:0] samp;
        bit flipped;
        if (!rst_n) begin
            model_clear();
            return;
        end
        samp = m_d2;
        m_d2 = m_d1;
        m_d1 = raw;
        exp_pulse = '0;
        for (int c = 0; c < NB; c++) begin
            flipped = 1'b0;
            if (samp[c] != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == D) begin
                    m_lvl[c] = samp[c];
                    m_run[c] = 0;
                    flipped  = 1'b1;
                    if (samp[c]) begin
                        exp_pulse[c] = 1'b1;
                        m_hold[c]    = 0;
                    end
                end
            end else begin
                m_run[c] = 0;
            end
            if (AR && !flipped && m_lvl[c] && samp[c]) begin
                if (m_prev[c]) begin
                    m_hold[c]++;
                    if (m_hold[c] == RD || (m_hold[c] > RD && (m_hold[c] - RD) % RP == 0))
                        exp_pulse[c] = 1'b1;
                end else begin
                    m_hold[c] = 0;
                end
            end
            m_prev[c] = samp[c];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        int first;
        rst_n = 1'b0;
        raw   = 3'b111;
        model_clear();
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if ({pulse, level} !== 6'b0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d pulse=%b level=%b want 0/0", i, pulse, level);
            end
        end
        rst_n = 1'b1;
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (pulse[0] && first < 0) first = i;
            total++;
            if ({pulse, level} !== {exp_pulse, m_lvl}) begin
                bad++;
                $display("FAIL reset_release cyc=%0d got=%b/%b want=%b/%b", i, pulse, level, exp_pulse, m_lvl);
            end
        end
        total++;
        if (first !== 6) begin
            bad++;
            $display("FAIL reset_first_pulse got=%0d want=6", first);
        end
        raw = '0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if ({pulse, level} !== {exp_pulse, m_lvl}) begin
                bad++;
                $display("FAIL reset_drop cyc=%0d got=%b/%b want=%b/%b", i, pulse, level, exp_pulse, m_lvl);
            end
        end
    endtask

    task automatic test_clean_press();
        int first, fall, npulse;
        first = -1; fall = -1; npulse = 0;
        raw = 3'b001;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (pulse[0]) begin
                npulse++;
                if (first < 0) first = i;
            end
            total++;
            if ({pulse, level} !== {exp_pulse, m_lvl}) begin
                bad++;
                $display("FAIL clean_hold cyc=%0d got=%b/%b want=%b/%b", i, pulse, level, exp_pulse, m_lvl);
            end
        end
        raw = 3'b000;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (!level[0] && fall < 0) fall = i;
            if (pulse[0]) npulse++;
            total++;
            if ({pulse, level} !== {exp_pulse, m_lvl}) begin
                bad++;
                $display("FAIL clean_release cyc=%0d got=%b/%b want=%b/%b", i, pulse, level, exp_pulse, m_lvl);
            end
        end
        total++;
        if (first !== 6 || fall !== 6) begin
            bad++;
            $display("FAIL clean_timing pulse_at=%0d fall_at=%0d want 6/6", first, fall);
        end
        total++;
        if (npulse !== (AR ? 2 : 1)) begin
            bad++;
            $display("FAIL clean_count got=%0d want=%0d", npulse, AR ? 2 : 1);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] pat;
        int first, npulse;
        pat = 4'b0101;
        first = -1; npulse = 0;
        for (int i = 0; i < 24; i++) begin
            if (i < 4)       raw = {1'b0, pat[i], 1'b0};
            else if (i < 18) raw = 3'b010;
            else             raw = 3'b000;
            tick();
            if (pulse[1]) begin
                npulse++;
                if (first < 0) first = i - 3;
            end
            total++;
            if ({pulse, level} !== {exp_pulse, m_lvl}) begin
                bad++;
                $display("FAIL bounce cyc=%0d got=%b/%b want=%b/%b", i, pulse, level, exp_pulse, m_lvl);
            end
        end
        total++;
        if (first !== 6 || npulse !== 1) begin
            bad++;
            $display("FAIL bounce_pulse at=%0d count=%0d want at=6 count=1", first, npulse);
        end
    endtask

    task automatic test_release_bounce();
        int npulse;
        bit dropped;
        npulse = 0; dropped = 1'b0;
        for (int i = 0; i < 36; i++) begin
            if (i < 12)      raw = 3'b100;
            else if (i < 14) raw = 3'b000;
            else if (i < 26) raw = 3'b100;
            else             raw = 3'b000;
            tick();
            if (pulse[2]) npulse++;
            if (i >= 6 && i < 26 && !level[2]) dropped = 1'b1;
            total++;
            if ({pulse, level} !== {exp_pulse, m_lvl}) begin
                bad++;
                $display("FAIL rel_bounce cyc=%0d got=%b/%b want=%b/%b", i, pulse, level, exp_pulse, m_lvl);
            end
        end
        total++;
        if (npulse !== 1 || dropped) begin
            bad++;
            $display("FAIL rel_bounce_summary pulses=%0d level_dropped=%0d want 1/0", npulse, dropped);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= 20; i++) begin
            raw = (i <= 10) ? 3'b101 : 3'b000;
            tick();
            if (i == 6) begin
                total++;
                if (pulse !== 3'b101) begin
                    bad++;
                    $display("FAIL simul_pulse got=%b want=101", pulse);
                end
            end
            total++;
            if ({pulse, level} !== {exp_pulse, m_lvl}) begin
                bad++;
                $display("FAIL simul cyc=%0d got=%b/%b want=%b/%b", i, pulse, level, exp_pulse, m_lvl);
            end
        end
    endtask

    task automatic test_autorepeat();
        int seen[$];
        int want[$];
        want = AR ? '{6, 26, 34, 42, 50, 58} : '{6};
        raw = 3'b001;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (pulse[0]) seen.push_back(i);
            total++;
            if ({pulse, level} !== {exp_pulse, m_lvl}) begin
                bad++;
                $display("FAIL repeat_hold cyc=%0d got=%b/%b want=%b/%b", i, pulse, level, exp_pulse, m_lvl);
            end
        end
        total++;
        if (seen.size() != want.size()) begin
            bad++;
            $display("FAIL repeat_count got=%0d want=%0d", seen.size(), want.size());
        end else begin
            foreach (want[k]) begin
                total++;
                if (seen[k] !== want[k]) begin
                    bad++;
                    $display("FAIL repeat_at idx=%0d got=%0d want=%0d", k, seen[k], want[k]);
                end
            end
        end
        raw = 3'b000;
        for (int i = 1; i <= 10; i++) tick();
        raw = 3'b001;
        for (int i = 1; i <= 30; i++) tick();
        rst_n = 1'b0;
        model_clear();
        #1;
        total++;
        if ({pulse, level} !== 6'b0) begin
            bad++;
            $display("FAIL repeat_reset_now got=%b/%b want 0/0", pulse, level);
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if ({pulse, level} !== 6'b0) begin
                bad++;
                $display("FAIL repeat_in_reset cyc=%0d got=%b/%b want 0/0", i, pulse, level);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        raw   = 3'b000;
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if ({pulse, level} !== {exp_pulse, m_lvl}) begin
                bad++;
                $display("FAIL repeat_after_reset cyc=%0d got=%b/%b want=%b/%b", i, pulse, level, exp_pulse, m_lvl);
            end
        end
    endtask

    task automatic test_random();
        logic [NB-1:0] prev_pulse;
        int unsigned len;
        prev_pulse = '0;
        for (int s = 0; s < 80; s++) begin
            raw = NB'($urandom);
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
            if (s > 0 && $urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                model_clear();
                prev_pulse = '0;
                #1;
                total++;
                if ({pulse, level} !== 6'b0) begin
                    bad++;
                    $display("FAIL rand_reset seg=%0d got=%b/%b want 0/0", s, pulse, level);
                end
                tick();
                rst_n = 1'b1;
            end
            for (int unsigned i = 0; i < len; i++) begin
                tick();
                total++;
                if ({pulse, level} !== {exp_pulse, m_lvl}) begin
                    bad++;
                    $display("FAIL rand seg=%0d cyc=%0d got=%b/%b want=%b/%b", s, i, pulse, level, exp_pulse, m_lvl);
                end
                total++;
                if ((pulse & prev_pulse) !== '0) begin
                    bad++;
                    $display("FAIL rand_back_to_back seg=%0d got=%b prev=%b want no overlap", s, pulse, prev_pulse);
                end
                prev_pulse = pulse;
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_simultaneous();
        test_autorepeat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
